srambank_ctrl_64x4x16: RTL

SRAMBANK_CTRL_64X4X16 -- requirements
Module: srambank_ctrl_64x4x16

---
 rtl/srambank_ctrl_64x4x16.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/srambank_ctrl_64x4x16.sv
// ---------------------------------------------------------------------------
// srambank_ctrl_64x4x16
// Single-bank SRAM controller. Requests are registered onto the bank pins the
// cycle after acceptance. Read data comes back through a two-stage tag
// pipeline (issue, capture) into a small response FIFO. A credit counter
// covering the pipeline and the FIFO gates req_ready, so the FIFO can never
// overflow.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   req_valid/req_ready             request handshake
//   req_write, req_addr, req_wdata  request payload (1 = write)
//   rsp_valid/rsp_ready, rsp_rdata  in-order read responses
//   ADDRESS, wd, banksel, read, write  registered bank drive
//   dataout                         bank read data (one cycle after sample)
// ---------------------------------------------------------------------------
module srambank_ctrl_64x4x16 #(
    parameter int unsigned AW        = 8,
    parameter int unsigned DW        = 16,
    parameter int unsigned RSP_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic [AW-1:0] ADDRESS,
    output logic [DW-1:0] wd,
    output logic          banksel,
    output logic          read,
    output logic          write,
    input  logic [DW-1:0] dataout
);

    localparam int unsigned PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int unsigned CW = $clog2(RSP_DEPTH + 1);

    // The 'read' output doubles as the issue-stage tag; cap_q is the capture stage.
    logic          cap_q;
    logic [DW-1:0] fifo_mem [RSP_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, credits_q;

    logic          accept_c, rd_accept_c, push_c, pop_c;
    logic [PW-1:0] wr_ptr_n, rd_ptr_n;
    logic [CW-1:0] count_n, credits_n;
    logic [DW-1:0] head_n;
    logic          ready_n;

    // Handshake decode
    always_comb begin
        accept_c    = req_valid & req_ready;
        rd_accept_c = accept_c & ~req_write;
        push_c      = cap_q;
        pop_c       = rsp_valid & rsp_ready;
    end

    // Next-state for credits, FIFO pointers/occupancy and registered head
    always_comb begin
        credits_n = credits_q;
        count_n   = count_q;
        wr_ptr_n  = wr_ptr_q + PW'(push_c);
        rd_ptr_n  = rd_ptr_q + PW'(pop_c);
        head_n    = fifo_mem[rd_ptr_n];
        ready_n   = 1'b1;

        case ({rd_accept_c, pop_c})
            2'b10:   credits_n = credits_q + CW'(1);
            2'b01:   credits_n = credits_q - CW'(1);
            default: credits_n = credits_q;
        endcase

        case ({push_c, pop_c})
            2'b10:   count_n = count_q + CW'(1);
            2'b01:   count_n = count_q - CW'(1);
            default: count_n = count_q;
        endcase

        // The entry being written this edge becomes the new head when the
        // FIFO is otherwise empty after the pop; memory still holds old data.
        if (push_c && (wr_ptr_q == rd_ptr_n)) begin
            head_n = dataout;
        end

        ready_n = (credits_n < CW'(RSP_DEPTH));
    end

    // Bank drive and tag pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ADDRESS <= '0;
            wd      <= '0;
            banksel <= 1'b0;
            read    <= 1'b0;
            write   <= 1'b0;
            cap_q   <= 1'b0;
        end else begin
            if (accept_c) begin
                ADDRESS <= req_addr;
                wd      <= req_wdata;
            end
            banksel <= accept_c;
            read    <= rd_accept_c;
            write   <= accept_c & req_write;
            cap_q   <= read;
        end
    end

    // Response FIFO, credits and registered response/ready outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(RSP_DEPTH); i++) begin
                fifo_mem[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            credits_q <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            req_ready <= 1'b1;
        end else begin
            if (push_c) begin
                fifo_mem[wr_ptr_q] <= dataout;
            end
            wr_ptr_q  <= wr_ptr_n;
            rd_ptr_q  <= rd_ptr_n;
            count_q   <= count_n;
            credits_q <= credits_n;
            rsp_valid <= (count_n != '0);
            rsp_rdata <= head_n;
            req_ready <= ready_n;
        end
    end

endmodule
